// File: rtl/expr_pipe_eval.sv
// Two-stage, multi-channel evaluator for mixed-signedness "a op b" expressions.
// Stage 1 registers extended operands; stage 2 evaluates, accumulates and holds results.
module expr_pipe_eval #(
  parameter int unsigned W   = 6,
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*4-1:0]      in_op,
  input  logic [NCH*W-1:0]      in_a,
  input  logic [NCH*W-1:0]      in_b,
  input  logic [NCH*2-1:0]      in_sgn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*(W+1)-1:0]  out_y,
  output logic [NCH-1:0]        out_err,
  output logic                  err_sticky,
  output logic [CW-1:0]         txn_count
);

  localparam int unsigned RW = W + 1;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpXnor = 4'd2;
  localparam logic [3:0] OpGe   = 4'd3;
  localparam logic [3:0] OpAshr = 4'd4;
  localparam logic [3:0] OpMul  = 4'd5;
  localparam logic [3:0] OpRed  = 4'd6;
  localparam logic [3:0] OpSel  = 4'd7;
  localparam logic [3:0] OpAcc  = 4'd8;
  localparam logic [3:0] OpClr  = 4'd9;

  typedef logic [RW-1:0] rw_t;
  typedef logic [W-1:0]  w_t;

  // Handshake / stage control
  logic s1_valid_q, s1_valid_d;
  logic s1_load, s2_load, out_hs;

  // Stage 1 operand registers
  logic [3:0]     s1_op_q   [NCH];
  logic [3:0]     s1_op_d   [NCH];
  rw_t            s1_ea_q   [NCH];
  rw_t            s1_ea_d   [NCH];
  rw_t            s1_eb_q   [NCH];
  rw_t            s1_eb_d   [NCH];
  rw_t            s1_sa_q   [NCH];
  rw_t            s1_sa_d   [NCH];
  w_t             s1_a_q    [NCH];
  w_t             s1_a_d    [NCH];
  w_t             s1_b_q    [NCH];
  w_t             s1_b_d    [NCH];
  logic [NCH-1:0] s1_sctx_q, s1_sctx_d;

  // Stage 2 results and accumulators
  rw_t                 acc_q [NCH];
  rw_t                 acc_d [NCH];
  rw_t                 res_d [NCH];
  logic [NCH-1:0]      ge_d;
  logic                out_valid_q, out_valid_d;
  logic [NCH*RW-1:0]   out_y_q, out_y_d;
  logic [NCH-1:0]      out_err_q, out_err_d;
  logic                err_sticky_q, err_sticky_d;
  logic [CW-1:0]       txn_q, txn_d;

  assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign s1_load  = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  assign s1_valid_d  = s1_load | (s1_valid_q & ~s2_load);
  assign out_valid_d = s2_load | (out_valid_q & ~out_ready);

  // Operand extension: the expression context is signed only if both operands are signed,
  // while the ASHR source follows the signedness of a alone.
  always_comb begin
    s1_sctx_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      s1_a_d[c]    = in_a[c*W +: W];
      s1_b_d[c]    = in_b[c*W +: W];
      s1_op_d[c]   = in_op[c*4 +: 4];
      s1_sctx_d[c] = in_sgn[2*c] & in_sgn[2*c+1];
      s1_ea_d[c]   = s1_sctx_d[c] ? {s1_a_d[c][W-1], s1_a_d[c]} : {1'b0, s1_a_d[c]};
      s1_eb_d[c]   = s1_sctx_d[c] ? {s1_b_d[c][W-1], s1_b_d[c]} : {1'b0, s1_b_d[c]};
      s1_sa_d[c]   = in_sgn[2*c] ? {s1_a_d[c][W-1], s1_a_d[c]} : {1'b0, s1_a_d[c]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_sctx_q <= s1_sctx_d;
      for (int unsigned c = 0; c < NCH; c++) begin
        s1_op_q[c] <= s1_op_d[c];
        s1_ea_q[c] <= s1_ea_d[c];
        s1_eb_q[c] <= s1_eb_d[c];
        s1_sa_q[c] <= s1_sa_d[c];
        s1_a_q[c]  <= s1_a_d[c];
        s1_b_q[c]  <= s1_b_d[c];
      end
    end
  end

  // Stage 2 evaluation
  always_comb begin
    out_y_d   = '0;
    out_err_d = '0;
    ge_d      = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      acc_d[c] = acc_q[c];
      res_d[c] = '0;
      ge_d[c]  = s1_sctx_q[c] ? ($signed(s1_ea_q[c]) >= $signed(s1_eb_q[c]))
                              : (s1_ea_q[c] >= s1_eb_q[c]);
      case (s1_op_q[c])
        OpAdd:   res_d[c] = s1_ea_q[c] + s1_eb_q[c];
        OpSub:   res_d[c] = s1_ea_q[c] - s1_eb_q[c];
        OpXnor:  res_d[c] = s1_ea_q[c] ^ ~s1_eb_q[c];
        OpGe:    res_d[c] = {{(RW-1){1'b0}}, ge_d[c]};
        OpAshr:  res_d[c] = rw_t'($signed(s1_sa_q[c]) >>> s1_b_q[c]);
        OpMul:   res_d[c] = s1_ea_q[c] * s1_eb_q[c];
        OpRed:   res_d[c] = {{(RW-2){1'b0}}, ^s1_a_q[c], &s1_b_q[c]};
        OpSel:   res_d[c] = (s1_b_q[c] != '0) ? s1_ea_q[c] : ~s1_ea_q[c];
        OpAcc: begin
          res_d[c] = acc_q[c] + s1_ea_q[c];
          acc_d[c] = acc_q[c] + s1_ea_q[c];
        end
        OpClr: begin
          res_d[c] = acc_q[c];
          acc_d[c] = '0;
        end
        default: out_err_d[c] = 1'b1;
      endcase
      out_y_d[c*RW +: RW] = res_d[c];
    end
  end

  always_comb begin
    err_sticky_d = err_sticky_q;
    txn_d        = txn_q;
    if (out_hs) begin
      err_sticky_d = err_sticky_q | (|out_err_q);
      txn_d        = txn_q + CW'(1);
    end
  end

  // Accumulators advance only with stage 2, so a stalled beat never updates them twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_y_q      <= '0;
      out_err_q    <= '0;
      err_sticky_q <= 1'b0;
      txn_q        <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      out_valid_q  <= out_valid_d;
      err_sticky_q <= err_sticky_d;
      txn_q        <= txn_d;
      if (s2_load) begin
        out_y_q   <= out_y_d;
        out_err_q <= out_err_d;
        for (int unsigned c = 0; c < NCH; c++) begin
          acc_q[c] <= acc_d[c];
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;
  assign txn_count  = txn_q;

endmodule

// File: tb/tb_expr_pipe_eval.sv
// Directed bench for expr_pipe_eval: latency, opcodes, accumulators, backpressure,
// reserved opcodes and mid-flight reset.
module tb_expr_pipe_eval;

  localparam int W   = 6;
  localparam int NCH = 4;
  localparam int RW  = 7;
  localparam int CW  = 16;
  localparam int YW  = NCH * RW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NCH*4-1:0]  in_op = '0;
  logic [NCH*W-1:0]  in_a = '0;
  logic [NCH*W-1:0]  in_b = '0;
  logic [NCH*2-1:0]  in_sgn = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [YW-1:0]     out_y;
  logic [NCH-1:0]    out_err;
  logic              err_sticky;
  logic [CW-1:0]     txn_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic tog_done;

  logic [YW-1:0]  y_q[$];
  logic [NCH-1:0] e_q[$];

  always #5 clk = ~clk;

  expr_pipe_eval #(.W(W), .NCH(NCH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sgn     (in_sgn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .txn_count  (txn_count)
  );

  // Records each beat whose handshake completes at the following rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      y_q.push_back(out_y);
      e_q.push_back(out_err);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [RW-1:0] chy(input logic [YW-1:0] y, input int c);
    return y[c*RW +: RW];
  endfunction

  task automatic clear_beat();
    in_op = '0; in_a = '0; in_b = '0; in_sgn = '0;
  endtask

  task automatic set_ch(input int c, input logic [3:0] op, input logic [5:0] a,
                        input logic [5:0] b, input logic [1:0] sg);
    in_op[c*4 +: 4]  = op;
    in_a[c*W +: W]   = a;
    in_b[c*W +: W]   = b;
    in_sgn[c*2 +: 2] = sg;
  endtask

  // Holds in_valid until the beat is accepted; returns just after the accepting edge.
  task automatic send_beat();
    logic rdy;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) return;
    end
    total_cnt++;
    $display("FAIL send_beat: beat not accepted within 100 cycles");
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (y_q.size() < n && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (y_q.size() < n) begin
      total_cnt++;
      $display("FAIL wait_results: got %0d beats, want %0d", y_q.size(), n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    y_q.delete();
    e_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_y !== '0) $display("FAIL rst_out_y: got %h want 0", out_y);
    else pass_cnt++;
    total_cnt++;
    if (out_err !== '0) $display("FAIL rst_out_err: got %b want 0", out_err);
    else pass_cnt++;
    total_cnt++;
    if (err_sticky !== 1'b0) $display("FAIL rst_err_sticky: got %b want 0", err_sticky);
    else pass_cnt++;
    total_cnt++;
    if (txn_count !== '0) $display("FAIL rst_txn: got %0d want 0", txn_count);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_add_latency();
    logic [1:0]    sg [2];
    logic [RW-1:0] ex [2];
    sg = '{2'b11, 2'b01};
    ex = '{7'h00, 7'h40};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clear_beat();
      set_ch(0, 4'd0, 6'h3F, 6'h01, sg[i]);
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL add_in_ready: got %b want 1", in_ready);
      else pass_cnt++;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL add_lat1: out_valid got %b want 0", out_valid);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL add_lat2: out_valid got %b want 1", out_valid);
      else pass_cnt++;
      total_cnt++;
      if (chy(out_y, 0) !== ex[i]) $display("FAIL add_y%0d: got %h want %h", i, chy(out_y, 0), ex[i]);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    y_q.delete();
    e_q.delete();
  endtask

  task automatic test_ge_ashr();
    logic [3:0]    op [6];
    logic [5:0]    a  [6];
    logic [5:0]    b  [6];
    logic [1:0]    sg [6];
    logic [RW-1:0] ex [6];
    op = '{4'd3,  4'd3,  4'd4,  4'd4,  4'd4,  4'd4};
    a  = '{6'h3E, 6'h3E, 6'h30, 6'h30, 6'h30, 6'h30};
    b  = '{6'h03, 6'h03, 6'h02, 6'h02, 6'h09, 6'h09};
    sg = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
    ex = '{7'h00, 7'h01, 7'h7C, 7'h0C, 7'h7F, 7'h00};
    y_q.delete();
    e_q.delete();
    for (int i = 0; i < 6; i++) begin
      clear_beat();
      set_ch(0, op[i], a[i], b[i], sg[i]);
      send_beat();
    end
    in_valid = 1'b0;
    wait_results(6);
    for (int i = 0; i < 6 && i < y_q.size(); i++) begin
      total_cnt++;
      if (y_q[i] !== YW'(ex[i])) $display("FAIL ge_ashr_%0d: got %h want %h", i, y_q[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mixed();
    logic [YW-1:0] ex [2];
    ex = '{{7'h03, 7'h76, 7'h43, 7'h7D}, {7'h00, 7'h01, 7'h65, 7'h7A}};
    y_q.delete();
    e_q.delete();
    clear_beat();
    set_ch(0, 4'd1, 6'h02, 6'h05, 2'b00);
    set_ch(1, 4'd2, 6'h0F, 6'h33, 2'b00);
    set_ch(2, 4'd5, 6'h05, 6'h3E, 2'b11);
    set_ch(3, 4'd6, 6'h07, 6'h3F, 2'b00);
    send_beat();
    clear_beat();
    set_ch(0, 4'd7, 6'h05, 6'h00, 2'b00);
    set_ch(1, 4'd7, 6'h25, 6'h01, 2'b11);
    set_ch(2, 4'd3, 6'h03, 6'h03, 2'b00);
    set_ch(3, 4'd6, 6'h03, 6'h3E, 2'b00);
    send_beat();
    in_valid = 1'b0;
    wait_results(2);
    for (int i = 0; i < 2 && i < y_q.size(); i++) begin
      total_cnt++;
      if (y_q[i] !== ex[i]) $display("FAIL mixed_%0d: got %h want %h", i, y_q[i], ex[i]);
      else pass_cnt++;
      total_cnt++;
      if (e_q[i] !== '0) $display("FAIL mixed_err_%0d: got %b want 0", i, e_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_acc_chain();
    logic [3:0]    op [6];
    logic [5:0]    a  [6];
    logic [RW-1:0] ex [6];
    logic [YW-1:0] ey;
    op = '{4'd8,  4'd8,  4'd8,  4'd9,  4'd8,  4'd9};
    a  = '{6'h05, 6'h07, 6'h3D, 6'h00, 6'h01, 6'h00};
    ex = '{7'h05, 7'h0C, 7'h09, 7'h09, 7'h01, 7'h01};
    for (int r = 0; r < 2; r++) begin
      y_q.delete();
      e_q.delete();
      out_ready = 1'b1;
      tog_done = 1'b1;
      if (r == 1) begin
        tog_done = 1'b0;
        fork
          begin
            for (int t = 0; t < 30; t++) begin
              @(posedge clk);
              #1;
              out_ready = ~out_ready;
            end
            out_ready = 1'b1;
            tog_done = 1'b1;
          end
        join_none
      end
      for (int i = 0; i < 6; i++) begin
        clear_beat();
        set_ch(2, op[i], a[i], 6'h00, 2'b11);
        send_beat();
      end
      in_valid = 1'b0;
      wait_results(6);
      while (!tog_done) begin
        @(posedge clk);
        #1;
      end
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (y_q.size() !== 6) $display("FAIL acc_count_r%0d: got %0d want 6", r, y_q.size());
      else pass_cnt++;
      for (int i = 0; i < 6 && i < y_q.size(); i++) begin
        ey = '0;
        ey[2*RW +: RW] = ex[i];
        total_cnt++;
        if (y_q[i] !== ey) $display("FAIL acc_r%0d_%0d: got %h want %h", r, i, y_q[i], ey);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    int nb;
    logic rdy;
    do_reset();
    out_ready = 1'b0;
    nb = 0;
    clear_beat();
    set_ch(0, 4'd0, 6'(nb + 1), 6'h00, 2'b00);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      rdy = in_ready;
      if (out_valid) begin
        total_cnt++;
        if (out_y !== YW'(1)) $display("FAIL bp_hold_c%0d: got %h want %h", cyc, out_y, YW'(1));
        else pass_cnt++;
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        nb++;
        clear_beat();
        set_ch(0, 4'd0, 6'(nb + 1), 6'h00, 2'b00);
      end
    end
    total_cnt++;
    if (nb !== 2) $display("FAIL bp_accepted: got %0d want 2", nb);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && nb < 6; cyc++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        nb++;
        clear_beat();
        set_ch(0, 4'd0, 6'(nb + 1), 6'h00, 2'b00);
      end
    end
    in_valid = 1'b0;
    wait_results(6);
    total_cnt++;
    if (y_q.size() !== 6) $display("FAIL bp_count: got %0d want 6", y_q.size());
    else pass_cnt++;
    for (int i = 0; i < 6 && i < y_q.size(); i++) begin
      total_cnt++;
      if (y_q[i] !== YW'(i + 1)) $display("FAIL bp_order_%0d: got %h want %h", i, y_q[i], YW'(i + 1));
      else pass_cnt++;
    end
    total_cnt++;
    if (txn_count !== 16'd6) $display("FAIL bp_txn: got %0d want 6", txn_count);
    else pass_cnt++;
  endtask

  task automatic test_reserved();
    int bad;
    y_q.delete();
    e_q.delete();
    out_ready = 1'b1;
    total_cnt++;
    if (err_sticky !== 1'b0) $display("FAIL rsv_sticky_pre: got %b want 0", err_sticky);
    else pass_cnt++;
    clear_beat();
    set_ch(3, 4'd8, 6'h05, 6'h00, 2'b11);
    send_beat();
    clear_beat();
    set_ch(0, 4'd0, 6'h01, 6'h01, 2'b00);
    set_ch(3, 4'hC, 6'h03, 6'h07, 2'b11);
    send_beat();
    in_valid = 1'b0;
    wait_results(2);
    if (y_q.size() >= 2) begin
      total_cnt++;
      if (e_q[1] !== 4'b1000) $display("FAIL rsv_err: got %b want 1000", e_q[1]);
      else pass_cnt++;
      total_cnt++;
      if (y_q[1] !== YW'(2)) $display("FAIL rsv_y: got %h want %h", y_q[1], YW'(2));
      else pass_cnt++;
    end
    total_cnt++;
    if (err_sticky !== 1'b1) $display("FAIL rsv_sticky_set: got %b want 1", err_sticky);
    else pass_cnt++;
    clear_beat();
    for (int i = 0; i < 20; i++) send_beat();
    in_valid = 1'b0;
    wait_results(22);
    bad = 0;
    for (int i = 2; i < y_q.size(); i++) if (e_q[i] !== '0 || y_q[i] !== '0) bad++;
    total_cnt++;
    if (bad !== 0) $display("FAIL rsv_clean_beats: got %0d bad beats want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (err_sticky !== 1'b1) $display("FAIL rsv_sticky_hold: got %b want 1", err_sticky);
    else pass_cnt++;
    clear_beat();
    set_ch(3, 4'd9, 6'h00, 6'h00, 2'b11);
    send_beat();
    in_valid = 1'b0;
    wait_results(23);
    if (y_q.size() >= 23) begin
      total_cnt++;
      if (chy(y_q[22], 3) !== 7'h05) $display("FAIL rsv_acc_kept: got %h want 05", chy(y_q[22], 3));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    clear_beat();
    for (int c = 0; c < NCH; c++) set_ch(c, 4'd8, 6'h03, 6'h00, 2'b11);
    send_beat();
    clear_beat();
    for (int c = 0; c < NCH; c++) set_ch(c, 4'd0, 6'h09, 6'h02, 2'b00);
    send_beat();
    in_valid = 1'b0;
    do_reset();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rif_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (txn_count !== '0) $display("FAIL rif_txn: got %0d want 0", txn_count);
    else pass_cnt++;
    total_cnt++;
    if (err_sticky !== 1'b0) $display("FAIL rif_sticky: got %b want 0", err_sticky);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rif_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total_cnt++;
    if (y_q.size() !== 0) $display("FAIL rif_stale: got %0d beats want 0", y_q.size());
    else pass_cnt++;
    clear_beat();
    for (int c = 0; c < NCH; c++) set_ch(c, 4'd9, 6'h00, 6'h00, 2'b11);
    send_beat();
    in_valid = 1'b0;
    wait_results(1);
    if (y_q.size() >= 1) begin
      total_cnt++;
      if (y_q[0] !== '0) $display("FAIL rif_acc_zero: got %h want 0", y_q[0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_ge_ashr();
    test_mixed();
    test_acc_chain();
    test_backpressure();
    test_reserved();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/expr_pipe_eval.md
Name: expr_pipe_eval

Overview:
- Parametrised, pipelined successor to the flat combinational expression blocks.
- Evaluates NCH independent channels of mixed-signedness Verilog-style expressions, a op b, under a valid/ready handshake.
- Adds a per-channel accumulator, error reporting and a transaction counter.
- Sits between the expression stimulus generator and the result checker; results leave concatenated channel-wise, like the y bus of the combinational blocks.

Parameters:
- W, 6, operand width per channel (>=2).
- NCH, 4, number of channels.
- RW, W+1, result width per channel (derived; not overridable).
- CW, 16, width of txn_count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_op  in  NCH*4  opcode per channel; channel 0 in the LSBs.
- in_a  in  NCH*W  operand a per channel.
- in_b  in  NCH*W  operand b per channel.
- in_sgn  in  NCH*2  per channel: bit0 = a signed, bit1 = b signed.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  NCH*RW  results; channel 0 in the LSBs.
- out_err  out  NCH  reserved opcode seen on that channel in this beat.
- err_sticky  out  1  OR of every out_err ever delivered; cleared only by reset.
- txn_count  out  CW  number of completed output handshakes; wraps modulo 2^CW.

Behaviour:
- Reset (synchronous, active-high; takes priority over all other activity):
  - out_valid=0, out_y=0, out_err=0, err_sticky=0, txn_count=0, all accumulators=0, both stage valids=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards in-flight beats; nothing is emitted afterwards.
- Pipeline: S1 registers extended operands; S2 computes and registers outputs.
  - Latency is 2 cycles from the in handshake to out_valid when there is no stall.
  - Throughput is 1 beat/cycle.
- Advance rules:
  - S2 loads when S1 is valid and (!out_valid or out_ready).
  - S1 loads when in_valid and in_ready.
  - in_ready = !s1_valid or S2 loads this cycle.
  - in_ready depends combinationally only on out_ready and state, never on in_valid.
- Holding: while out_valid=1 and out_ready=0, out_y and out_err stay stable. At most 2 beats are held; no beat is dropped or duplicated, and order is preserved.
- Signedness (Verilog rules): the expression is signed only when both bit0 and bit1 are set.
  - Signed context: each operand is sign-extended to RW.
  - Unsigned context: each operand is zero-extended to RW.
  - Arithmetic wraps modulo 2^RW.
- Opcodes, with ea/eb the extended operands:
  - 0 ADD: ea+eb.
  - 1 SUB: ea-eb.
  - 2 XNOR: ea^~eb.
  - 3 GE: ea>=eb, compared signed or unsigned per context; 1-bit result zero-extended.
  - 4 ASHR: a extended by its own bit0 only, shifted >>> by unsigned b. Shift amount >= RW gives all sign bits (signed a) or all zeros.
  - 5 MUL: low RW bits of ea*eb.
  - 6 RED: {0..., ^a, &b}; bit0=&b, bit1=^a.
  - 7 SEL: (b!=0) ? ea : ~ea.
  - 8 ACC: result = acc+ea; acc <= result.
  - 9 CLR: result = acc; acc <= 0.
  - 10-15 reserved: result 0, out_err bit=1, acc unchanged.
- Accumulators:
  - Updated only when S2 loads, so back-to-back ACC beats chain correctly.
  - Unaffected by stalls; never updated twice for one beat.
- err_sticky and txn_count update only on the out handshake (out_valid and out_ready).

Test Plan:
- W=6, NCH=4; ch0 ADD a=6'h3F, b=6'h01:
  - in_sgn=2'b11 -> out_y ch0=7'h00.
  - in_sgn=2'b01 -> 7'h40.
  - out_valid exactly 2 cycles after the in handshake.
- GE and ASHR, signed vs unsigned:
  - GE a=6'h3E, b=6'h03: sgn=11 -> 0; sgn=01 -> 1.
  - ASHR a=6'h30, b=2: sgn=01 -> 7'h7C; sgn=00 -> 7'h0C.
  - ASHR a=6'h30 signed, b=9 -> 7'h7F.
- Accumulator chain on ch2 (signed):
  - ACC a=5,7,-3 back-to-back -> 7'h05, 7'h0C, 7'h09.
  - Then CLR -> 7'h09.
  - Then ACC a=1 -> 7'h01.
  - Repeat with out_ready toggling; identical sequence required.
- Backpressure: in_valid held high with incrementing operands, out_ready=0 for 5 cycles:
  - in_ready drops after exactly 2 accepted beats.
  - out_y stable throughout the stall.
  - On release, all beats arrive in order with none lost.
  - txn_count equals the number of handshakes.
- Reserved opcode 4'hC on ch3 only:
  - out_err=4'b1000 and ch3 result 0.
  - err_sticky=1 after that handshake and stays 1 through 20 clean beats.
  - The ch3 accumulator is unchanged.
- Reset with 2 beats in flight:
  - The next cycle shows out_valid=0, txn_count=0, err_sticky=0, accumulators=0, in_ready=1.
  - No stale beat appears afterwards.
